uart_word_packer: RTL and testbench



---
 rtl/uart_word_packer.sv | 137 +++++++++++++
 tb/tb_uart_word_packer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_packer.sv
// Packs received UART bytes little-endian into words, tags frame ends with TLAST,
// flushes partial words after an idle timeout and buffers words in an FWFT FIFO.
module uart_word_packer #(
    parameter int          C_M_AXIS_TDATA_WIDTH = 32,
    parameter int          C_FIFO_DEPTH         = 16,
    parameter int          C_FRAME_WORDS        = 256,
    parameter int unsigned C_TIMEOUT_CYCLES     = 100000
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [7:0]                      pi_rx_byte,
    input  logic                            pi_rx_valid,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] po_r_data,
    output logic                            po_tlast,
    output logic                            po_data_avaliable,
    input  logic                            pi_read_data,
    output logic [$clog2(C_FIFO_DEPTH):0]   po_fill_level,
    output logic                            po_overflow
);
    localparam int W  = C_M_AXIS_TDATA_WIDTH;
    localparam int N  = W / 8;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = (C_FRAME_WORDS > 1) ? $clog2(C_FRAME_WORDS) : 1;
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [BW-1:0] BIDX_LAST = BW'(N - 1);
    localparam logic [FW-1:0] WCNT_LAST = FW'(C_FRAME_WORDS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(C_FIFO_DEPTH);
    localparam logic [31:0]   IDLE_LAST = C_TIMEOUT_CYCLES - 1;

    logic [BW-1:0] bidx;
    logic [FW-1:0] wcnt;
    logic [31:0]   idle_cnt;
    logic [W-1:0]  lanes;

    logic [W-1:0]  word_in;
    logic          byte_push;
    logic          flush;
    logic          push_req;
    logic          push_last;
    logic          push_ok;
    logic          pop_ok;
    logic          fifo_empty;

    logic [W-1:0]  mem_data [C_FIFO_DEPTH];
    logic          mem_last [C_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    always_comb begin
        word_in = lanes;
        for (int unsigned k = 0; k < N; k++) begin
            if (pi_rx_valid && (bidx == BW'(k))) begin
                word_in[8*k +: 8] = pi_rx_byte;
            end
        end
        byte_push  = pi_rx_valid && (bidx == BIDX_LAST);
        // Idle counter is one behind the idle-cycle count, so compare with T-1.
        flush      = !pi_rx_valid && (bidx != '0) && (idle_cnt == IDLE_LAST);
        push_req   = byte_push || flush;
        push_last  = flush || (wcnt == WCNT_LAST);
        fifo_empty = (count == '0);
        pop_ok     = pi_read_data && !fifo_empty;
        push_ok    = push_req && ((count < DEPTH) || pop_ok);
    end

    assign po_data_avaliable = !fifo_empty;
    assign po_fill_level     = count;
    assign po_r_data         = fifo_empty ? '0 : mem_data[rd_ptr];
    assign po_tlast          = !fifo_empty && mem_last[rd_ptr];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bidx        <= '0;
            wcnt        <= '0;
            idle_cnt    <= '0;
            lanes       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            po_overflow <= 1'b0;
        end else begin
            // Lanes are cleared on every push so a flushed word has zero-filled upper lanes.
            if (pi_rx_valid) begin
                if (byte_push) begin
                    bidx  <= '0;
                    lanes <= '0;
                end else begin
                    bidx  <= bidx + BW'(1);
                    lanes <= word_in;
                end
            end else if (flush) begin
                bidx  <= '0;
                lanes <= '0;
            end

            if (pi_rx_valid || (bidx == '0) || flush) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end

            // Dropped words still advance framing.
            if (flush) begin
                wcnt <= '0;
            end else if (byte_push) begin
                wcnt <= (wcnt == WCNT_LAST) ? '0 : wcnt + FW'(1);
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (push_req && !push_ok) begin
                po_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET && push_ok) begin
            mem_data[wr_ptr] <= word_in;
            mem_last[wr_ptr] <= push_last;
        end
    end

endmodule

// File: tb/tb_uart_word_packer.sv
// Bench for uart_word_packer: directed and random byte streams, with a queue-based
// reference model feeding a scoreboard that a negedge monitor checks every cycle.
module tb_uart_word_packer;
    localparam int W = 32;
    localparam int D = 16;
    localparam int F = 3;
    localparam int T = 10;

    logic          ACLK;
    logic          ARESET;
    logic [7:0]    pi_rx_byte;
    logic          pi_rx_valid;
    logic [W-1:0]  po_r_data;
    logic          po_tlast;
    logic          po_data_avaliable;
    logic          pi_read_data;
    logic [4:0]    po_fill_level;
    logic          po_overflow;

    uart_word_packer #(
        .C_M_AXIS_TDATA_WIDTH(W),
        .C_FIFO_DEPTH(D),
        .C_FRAME_WORDS(F),
        .C_TIMEOUT_CYCLES(T)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .pi_rx_byte(pi_rx_byte),
        .pi_rx_valid(pi_rx_valid),
        .po_r_data(po_r_data),
        .po_tlast(po_tlast),
        .po_data_avaliable(po_data_avaliable),
        .pi_read_data(pi_read_data),
        .po_fill_level(po_fill_level),
        .po_overflow(po_overflow)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    // Reference model state: bytes of the open word, frame position, FIFO image.
    logic [7:0]  pend [$];
    int          idle = 0;
    int          fidx = 0;
    int          mcount = 0;
    bit          mov = 0;
    logic [32:0] exp_q [$];

    initial begin
        ACLK = 0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] w;
        logic        last;
        bit          push;
        bit          pop_ok;
        bit          push_ok;
        if (ARESET) begin
            pend.delete();
            idle = 0;
            fidx = 0;
            mcount = 0;
            mov = 0;
            exp_q.delete();
            return;
        end
        push = 0;
        w = 0;
        last = 0;
        if (pi_rx_valid) begin
            pend.push_back(pi_rx_byte);
            idle = 0;
            if (pend.size() == W / 8) begin
                foreach (pend[i]) w = w | (32'(pend[i]) << (8 * i));
                last = (fidx == F - 1);
                fidx = (fidx + 1) % F;
                push = 1;
                pend.delete();
            end
        end else if (pend.size() > 0) begin
            idle++;
            if (idle == T) begin
                foreach (pend[i]) w = w | (32'(pend[i]) << (8 * i));
                last = 1;
                fidx = 0;
                idle = 0;
                push = 1;
                pend.delete();
            end
        end
        pop_ok  = pi_read_data && (mcount > 0);
        push_ok = push && ((mcount < D) || pop_ok);
        if (push && !push_ok) mov = 1;
        mcount = mcount + int'(push_ok) - int'(pop_ok);
        if (push_ok) exp_q.push_back({last, w});
    endtask

    initial begin
        forever begin
            @(posedge ACLK);
            model_step();
        end
    end

    // Monitor: the head the DUT presents must match the scoreboard front every cycle.
    initial begin
        logic [32:0] dummy;
        forever begin
            @(negedge ACLK);
            if (mon_en) begin
                chk("fill_level", po_fill_level, mcount);
                chk("overflow", po_overflow, mov);
                if (exp_q.size() > 0) begin
                    chk("avail", po_data_avaliable, 1);
                    chk("head_data", po_r_data, exp_q[0][31:0]);
                    chk("head_tlast", po_tlast, exp_q[0][32]);
                    if (pi_read_data) dummy = exp_q.pop_front();
                end else begin
                    chk("avail_empty", po_data_avaliable, 0);
                    chk("data_empty", po_r_data, 0);
                    chk("tlast_empty", po_tlast, 0);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] b, input logic rd);
        pi_rx_valid  = v;
        pi_rx_byte   = b;
        pi_read_data = rd;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESET = 1;
        cyc(0, 8'h00, 0);
        ARESET = 0;
        mon_en = 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && po_data_avaliable; i++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        chk("drained", po_fill_level, 0);
    endtask

    task automatic send_word(input logic [31:0] w, input logic rd_last);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] t;
            t = w >> (8 * k);
            cyc(1, t[7:0], (k == 3) ? rd_last : 1'b0);
        end
    endtask

    function automatic logic rdsel();
        return ($urandom_range(0, 1) == 1) || (po_fill_level >= 12);
    endfunction

    initial begin
        ARESET = 0;
        pi_rx_valid = 0;
        pi_rx_byte = 0;
        pi_read_data = 0;
        @(posedge ACLK);
        #1;

        // 1: single word, then pop
        do_reset();
        chk("reset_avail", po_data_avaliable, 0);
        chk("reset_fill", po_fill_level, 0);
        chk("reset_ovf", po_overflow, 0);
        send_word(32'h44332211, 0);
        chk("t1_data", po_r_data, 32'h44332211);
        chk("t1_tlast", po_tlast, 0);
        chk("t1_fill", po_fill_level, 1);
        cyc(0, 8'h00, 1);
        chk("t1_pop_avail", po_data_avaliable, 0);
        chk("t1_pop_data", po_r_data, 0);

        // 2: framing with 3 words per frame
        do_reset();
        for (int i = 0; i < 4; i++) send_word(32'hA0B0C000 + 32'(i), 0);
        chk("t2_fill", po_fill_level, 4);
        chk("t2_w0_tlast", po_tlast, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);
        chk("t2_w2_tlast", po_tlast, 1);
        cyc(0, 8'h00, 1);
        chk("t2_w3_tlast", po_tlast, 0);
        drain();

        // 3: timeout flush of a partial word
        cyc(1, 8'hAA, 0);
        cyc(1, 8'hBB, 0);
        for (int i = 1; i <= T; i++) begin
            cyc(0, 8'h00, 0);
            if (i == T - 1) chk("t3_no_early_flush", po_data_avaliable, 0);
        end
        chk("t3_flush_avail", po_data_avaliable, 1);
        chk("t3_flush_data", po_r_data, 32'h0000BBAA);
        chk("t3_flush_tlast", po_tlast, 1);
        cyc(0, 8'h00, 1);
        for (int i = 0; i < 3; i++) send_word(32'h1234_5600 + 32'(i), 0);
        drain();

        // 4: overflow, then push with simultaneous pop when full
        do_reset();
        for (int i = 0; i < 16; i++) send_word($urandom, 0);
        chk("t4_full_fill", po_fill_level, 16);
        chk("t4_full_ovf", po_overflow, 0);
        send_word(32'hDEADBEEF, 0);
        chk("t4_drop_fill", po_fill_level, 16);
        chk("t4_drop_ovf", po_overflow, 1);
        send_word(32'hCAFEF00D, 1);
        chk("t4_pushpop_fill", po_fill_level, 16);
        drain();

        // 5: pop on empty, reset mid-word
        cyc(0, 8'h00, 1);
        chk("t5_empty_pop_fill", po_fill_level, 0);
        chk("t5_empty_pop_ovf", po_overflow, 1);
        do_reset();
        chk("t5_reset_ovf", po_overflow, 0);
        cyc(1, 8'h55, 0);
        cyc(1, 8'h66, 0);
        do_reset();
        send_word(32'h04030201, 0);
        chk("t5_new_word", po_r_data, 32'h04030201);
        chk("t5_ovf", po_overflow, 0);
        drain();

        // 6: random stream with random consumer
        do_reset();
        for (int w = 0; w < 64; w++) begin
            for (int k = 0; k < 4; k++) begin
                int gap;
                gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                repeat (gap) cyc(0, 8'h00, rdsel());
                cyc(1, 8'($urandom_range(0, 255)), rdsel());
            end
        end
        drain();
        chk("t6_ovf", po_overflow, 0);

        cyc(0, 8'h00, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
